// File: rtl/wb_seq_pkg.sv
// Shared types and defaults for the sequential Wishbone master.
package wb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int STRIDE_DEFAULT  = 4;
  localparam int WAIT_W          = 8;   // per-beat ack wait counter
  localparam int BEAT_W          = 8;   // remaining-beat counter

endpackage

// File: rtl/wb_seq_timeout.sv
// Per-beat ack wait counter: cleared while idle, counts while enabled,
// and flags expiry once it has waited TIMEOUT cycles.
module wb_seq_timeout
  import wb_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] count;

  // Wait counter: clear has priority over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n)      count <= '0;
    else if (clr)    count <= '0;
    else if (en)     count <= count + WAIT_W'(1);
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/wb_seq_master.sv
// Sequential Wishbone master: runs cmd_len single-beat classic cycles at
// STRIDE-spaced addresses and returns one response per beat.
module wb_seq_master
  import wb_seq_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int STRIDE  = STRIDE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_last,
  output logic        busy,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam logic [31:0] STRIDE_W = 32'(STRIDE);

  state_t            state_q, state_d;
  logic              ready_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [BEAT_W-1:0] beats_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;

  logic in_bus, in_rsp, accept, bus_ack, bus_expire, last_w, expired;

  assign in_bus     = (state_q == BUS);
  assign in_rsp     = (state_q == RSP);
  assign cmd_ready  = ready_q && (state_q == IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign bus_ack    = in_bus && wbm_ack_i;
  // Ack beats a simultaneous expiry.
  assign bus_expire = in_bus && !wbm_ack_i && expired;
  assign last_w     = in_rsp && ((beats_q == BEAT_W'(1)) || rsp_err_q);

  wb_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!in_bus),
    .en      (in_bus && !wbm_ack_i),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (bus_ack || bus_expire) state_d = RSP;
      RSP:     if (rsp_ready) state_d = last_w ? IDLE : BUS;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Command registers, beat bookkeeping and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      beats_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        sel_q     <= cmd_sel;
        we_q      <= cmd_we;
        beats_q   <= (cmd_len == 8'd0) ? BEAT_W'(1) : cmd_len;
        rsp_err_q <= 1'b0;
      end
      if (bus_ack) begin
        rsp_data_q <= we_q ? 32'd0 : wbm_dat_i;
        rsp_err_q  <= 1'b0;
      end else if (bus_expire) begin
        rsp_data_q <= 32'd0;
        rsp_err_q  <= 1'b1;
      end
      if (in_rsp && rsp_ready && !last_w) begin
        beats_q <= beats_q - BEAT_W'(1);
        addr_q  <= addr_q + STRIDE_W;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign wbm_cyc_o = in_bus;
  assign wbm_stb_o = in_bus;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = addr_q;
  assign wbm_dat_o = wdata_q;
  assign rsp_valid = in_rsp;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = in_rsp && rsp_err_q;
  assign rsp_last  = last_w;

endmodule

// File: tb/tb_wb_seq_master.sv
// Directed bench for wb_seq_master (TIMEOUT = 8, STRIDE = 4).
module tb_wb_seq_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  cmd_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic        busy;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  wb_seq_master #(.TIMEOUT(8), .STRIDE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_sel   (cmd_sel),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .busy      (busy),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Offer one command at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] sel, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_sel   = sel;
    cmd_len   = len;
    check("cmd_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = 32'hFFFF_FFFF;
  endtask

  // One bus beat: wait_n strobe cycles without ack, then ack with rd.
  task automatic beat(input string tag, input int wait_n, input logic [31:0] exp_adr,
                      input logic exp_we, input logic [31:0] rd);
    for (int i = 0; i < wait_n; i++) begin
      check({tag, " stb wait"}, wbm_stb_o, 1);
      check({tag, " adr wait"}, wbm_adr_o, exp_adr);
      @(negedge clk);
    end
    check({tag, " cyc"}, wbm_cyc_o, 1);
    check({tag, " stb"}, wbm_stb_o, 1);
    check({tag, " adr"}, wbm_adr_o, exp_adr);
    check({tag, " we"}, wbm_we_o, exp_we);
    wbm_ack_i = 1'b1;
    wbm_dat_i = rd;
    @(negedge clk);
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'hDEAD_BEEF;
  endtask

  // Check a pending response, then consume it.
  task automatic take_rsp(input string tag, input logic [31:0] exp_data,
                          input logic exp_err, input logic exp_last);
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " cyc low"}, wbm_cyc_o, 0);
    check({tag, " rsp_data"}, rsp_data, exp_data);
    check({tag, " rsp_err"}, rsp_err, exp_err);
    check({tag, " rsp_last"}, rsp_last, exp_last);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 0);
    check("rst busy", busy, 0);
    check("rst stb", wbm_stb_o, 0);
    check("rst rsp_valid", rsp_valid, 0);
    check("rst adr", wbm_adr_o, 0);
    rst_n = 1'b1;
    #1 check("rel cmd_ready pre-edge", cmd_ready, 0);
    @(negedge clk);
    check("rel cmd_ready", cmd_ready, 1);

    // Single write, ack on the third strobe cycle.
    send_cmd(1'b1, 32'h3800_0010, 32'hA5A5_0001, 4'hF, 8'd1);
    check("wr busy", busy, 1);
    check("wr dat", wbm_dat_o, 32'hA5A5_0001);
    check("wr sel", wbm_sel_o, 4'hF);
    beat("wr", 2, 32'h3800_0010, 1'b1, 32'h1234_5678);
    take_rsp("wr", 32'h0, 1'b0, 1'b1);
    check("wr idle", busy, 0);
    check("wr idle stb", wbm_stb_o, 0);

    // Four-beat read.
    send_cmd(1'b0, 32'h3800_0000, 32'h0, 4'hF, 8'd4);
    for (int b = 0; b < 4; b++) begin
      beat("rd4", 0, 32'h3800_0000 + 32'(4 * b), 1'b0, 32'h1111_0000 + 32'(b));
      take_rsp("rd4", 32'h1111_0000 + 32'(b), 1'b0, b == 3);
    end
    check("rd4 idle", busy, 0);

    // Backpressure on a two-beat read.
    send_cmd(1'b0, 32'h0000_0100, 32'h0, 4'h3, 8'd2);
    beat("bp1", 1, 32'h0000_0100, 1'b0, 32'hCAFE_0001);
    for (int i = 0; i < 5; i++) begin
      check("bp hold valid", rsp_valid, 1);
      check("bp hold data", rsp_data, 32'hCAFE_0001);
      check("bp hold last", rsp_last, 0);
      check("bp hold err", rsp_err, 0);
      check("bp no stb", wbm_stb_o, 0);
      @(negedge clk);
    end
    take_rsp("bp1", 32'hCAFE_0001, 1'b0, 1'b0);
    beat("bp2", 0, 32'h0000_0104, 1'b0, 32'hCAFE_0002);
    take_rsp("bp2", 32'hCAFE_0002, 1'b0, 1'b1);

    // Timeout: slave never acks on a three-beat read.
    send_cmd(1'b0, 32'h0000_0200, 32'h0, 4'hF, 8'd3);
    n = 0;
    while (wbm_stb_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("to stb cycles", n, 8);
    take_rsp("to", 32'h0, 1'b1, 1'b1);
    check("to idle", busy, 0);
    @(negedge clk);
    check("to no more beats", wbm_stb_o, 0);

    // Ack on the final timeout cycle wins.
    send_cmd(1'b0, 32'h0000_0300, 32'h0, 4'hF, 8'd1);
    beat("edge", 7, 32'h0000_0300, 1'b0, 32'h5A5A_0029);
    take_rsp("edge", 32'h5A5A_0029, 1'b0, 1'b1);

    // Reset during the second BUS cycle.
    send_cmd(1'b0, 32'h0000_0400, 32'h0, 4'hF, 8'd2);
    check("mr stb c1", wbm_stb_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr cyc", wbm_cyc_o, 0);
    check("mr stb", wbm_stb_o, 0);
    check("mr busy", busy, 0);
    check("mr rsp_valid", rsp_valid, 0);
    check("mr cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("mr no rsp", rsp_valid, 0);
      check("mr no stb", wbm_stb_o, 0);
      @(negedge clk);
    end

    // Recovery, with len 0 treated as a single beat.
    send_cmd(1'b1, 32'h0000_0500, 32'h0BAD_F00D, 4'h1, 8'd0);
    check("rc sel", wbm_sel_o, 4'h1);
    beat("rc", 0, 32'h0000_0500, 1'b1, 32'h7777_7777);
    take_rsp("rc", 32'h0, 1'b0, 1'b1);
    check("rc idle", busy, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/wb_seq_master.md
WB_SEQ_MASTER -- requirements
Module: wb_seq_master

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock and reset are named as elsewhere in the codebase: clk, rst_n.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of cycles waited for wbm_ack_i per beat (range 1..255).
REQ-003 Parameter STRIDE, default 4, SHALL set the byte-address increment between beats.
REQ-004 Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  32  start byte address
- cmd_wdata  in  32  write data, same value for every beat
- cmd_sel  in  4  byte lanes
- cmd_len  in  8  beat count; 0 is treated as 1
- rsp_valid  out  1  response beat available
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read data; 0 for writes
- rsp_err  out  1  beat timed out
- rsp_last  out  1  final beat of the command
- busy  out  1  not IDLE
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  4  Wishbone byte select
- wbm_adr_o  out  32  Wishbone address
- wbm_dat_o  out  32  Wishbone write data
- wbm_dat_i  in  32  Wishbone read data
- wbm_ack_i  in  1  Wishbone acknowledge

Function
REQ-005 The FSM SHALL have three states: IDLE, BUS, RSP.
REQ-006 cmd_ready SHALL equal (state == IDLE); the command SHALL be accepted on a cycle with cmd_valid && cmd_ready, and its fields SHALL be registered.
REQ-007 On acceptance the FSM SHALL move to BUS on the next edge, setting beats_left = max(cmd_len, 1) and addr = cmd_addr.
REQ-008 In BUS, wbm_cyc_o and wbm_stb_o SHALL be 1, and wbm_adr_o, wbm_we_o, wbm_sel_o and wbm_dat_o SHALL hold the registered values stable until ack or timeout.
REQ-009 In BUS with wbm_ack_i = 1, the block SHALL capture wbm_dat_i (reads) or 0 (writes), drop cyc/stb on the next edge, and enter RSP with rsp_err = 0.
REQ-010 An 8-bit wait counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-011 When the wait counter reaches TIMEOUT-1 without ack, the FSM SHALL enter RSP with rsp_err = 1, rsp_last = 1 and rsp_data = 0, and the remaining beats SHALL be abandoned.
REQ-012 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-013 wbm_ack_i SHALL be ignored outside BUS.
REQ-014 In RSP, rsp_valid SHALL be 1, cyc/stb SHALL be 0, and rsp_last SHALL be 1 when beats_left == 1 or rsp_err == 1.
REQ-015 In RSP with rsp_ready = 1:
- if rsp_last: the FSM SHALL go to IDLE;
- otherwise: beats_left SHALL decrement, addr SHALL advance by STRIDE (32-bit wrap, no carry out), and the FSM SHALL return to BUS.
REQ-016 Consecutive beats SHALL therefore be separated by at least one cycle with cyc/stb low.
REQ-017 rsp_data, rsp_err and rsp_last SHALL hold stable while rsp_valid && !rsp_ready.
REQ-018 Minimum latency SHALL be: cmd accept -> stb high 1 cycle; ack -> rsp_valid 1 cycle.

Reset
REQ-019 While rst_n = 0, all outputs SHALL be 0 except cmd_ready; cmd_ready SHALL be 0 during reset and 1 from the first edge after release.
REQ-020 Assertion of rst_n mid-operation (BUS or RSP) SHALL immediately drop cyc/stb, discard the command, and return the FSM to IDLE with no response emitted.
REQ-021 All counters and registers SHALL reset to 0.

Structure
REQ-022 Package wb_seq_pkg SHALL hold the state enum (IDLE, BUS, RSP), the TIMEOUT and STRIDE defaults, and the counter widths.
REQ-023 A single sub-module, wb_seq_timeout (clear/enable/expire counter), SHALL be used; everything else SHALL be flat.

Verification
REQ-024 Single write: cmd addr 0x38000010, data 0xA5A5_0001, sel 0xF, len 1; slave acks 3 cycles later -> one BUS phase with correct fields, one rsp with rsp_last = 1, rsp_err = 0, rsp_data = 0.
REQ-025 Four-beat read: addr 0x38000000, len 4, rsp_ready tied 1 -> wbm_adr_o sequence 0x38000000/04/08/0C, cyc low between beats, four rsp, last on beat 4, data matches slave.
REQ-026 Backpressure: read len 2 with rsp_ready low for 5 cycles -> rsp fields stable, no second BUS phase until ready.
REQ-027 Timeout: TIMEOUT = 8, slave never acks, len 3 -> stb high exactly 8 cycles, single rsp with err = 1, last = 1, then IDLE.
REQ-028 Reset mid-BUS: rst_n low at cycle 2 of BUS -> cyc/stb 0 immediately, no rsp, cmd_ready 1 one edge after release.
REQ-029 Same-cycle event: ack arrives on the final timeout cycle -> rsp_err = 0 and data captured.
